// File: rtl/tlb_params.sv
// Shared types for the multi-port TLB: entry layout, search request/result and flush FSM states.
package tlb_params;

    localparam int VPN2_W    = 19;
    localparam int ASID_W    = 8;
    localparam int PFN_W     = 20;
    // Result index is sized for the largest legal TLB (64 entries) and zero-extended.
    localparam int IDX_MAX_W = 6;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } page_t;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              is_global;
        page_t             page0;
        page_t             page1;
    } tlb_request_t;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic              is_odd_page;
        logic [ASID_W-1:0] asid;
    } search_request_t;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] index;
        page_t                page;
    } search_result_t;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_SWEEP = 2'd1,
        FLUSH_DONE  = 2'd2
    } flush_state_t;

    // Global entries survive an ASID flush; flush_all takes everything.
    function automatic logic flush_hits(input tlb_request_t e, input logic all,
                                        input logic [ASID_W-1:0] asid);
        return all | (~e.is_global & (e.asid == asid));
    endfunction

endpackage

// File: rtl/tlb_multiport_match_encoder.sv
// Reduces one port's match vector to found / lowest matching index / multi-hit.
module tlb_match_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     match,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic             multi_hit
);

    assign found     = |match;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hit = |(match & (match - N'(1)));

    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (match[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/tlb_multiport.sv
// Parametrised TLB: N lookup ports with registered results, Random/Wired pair for TLBWR,
// and a one-entry-per-cycle ASID-selective flush engine.
module tlb_multiport
    import tlb_params::*;
#(
    parameter int  TLB_NUM      = 16,
    parameter int  SEARCH_PORTS = 2,
    localparam int IDX_W        = $clog2(TLB_NUM)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    // Search: a port's request is taken on every edge where its search_valid is high; the
    // result appears one cycle later with result_valid. No backpressure exists.
    input  logic [SEARCH_PORTS-1:0]            search_valid,
    input  search_request_t [SEARCH_PORTS-1:0] search_request,
    output logic [SEARCH_PORTS-1:0]            result_valid,
    output search_result_t [SEARCH_PORTS-1:0]  search_result,
    output logic [SEARCH_PORTS-1:0]            multi_hit,
    input  logic                               write_enabled,
    input  logic                               write_random,
    input  logic [IDX_W-1:0]                   write_index,
    input  tlb_request_t                       write_data,
    input  logic                               wired_write,
    input  logic [IDX_W-1:0]                   wired_value,
    output logic [IDX_W-1:0]                   random_index,
    input  logic [IDX_W-1:0]                   read_index,
    output tlb_request_t                       read_data,
    output logic                               read_entry_valid,
    input  logic                               flush_request,
    input  logic                               flush_all,
    input  logic [ASID_W-1:0]                  flush_asid,
    output logic                               flush_busy,
    output logic                               flush_done,
    output flush_state_t                       flush_state
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(TLB_NUM - 1);

    tlb_request_t       entries [TLB_NUM];
    logic [TLB_NUM-1:0] entry_valid;

    flush_state_t       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic               flush_all_q;
    logic [ASID_W-1:0]  flush_asid_q;
    logic               sweep_clear;

    logic [IDX_W-1:0]   random_q, wired_q;
    logic [IDX_W-1:0]   wr_idx;

    // ---------------- flush FSM ----------------
    always_comb begin
        state_d     = state_q;
        sweep_clear = 1'b0;
        case (state_q)
            FLUSH_IDLE:  if (flush_request) state_d = FLUSH_SWEEP;
            FLUSH_SWEEP: begin
                sweep_clear = flush_hits(entries[ptr_q], flush_all_q, flush_asid_q);
                if (ptr_q == LAST) state_d = FLUSH_DONE;
            end
            FLUSH_DONE:  state_d = FLUSH_IDLE;
            default:     state_d = FLUSH_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FLUSH_IDLE;
            ptr_q        <= '0;
            flush_all_q  <= 1'b0;
            flush_asid_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FLUSH_IDLE && flush_request) begin
                ptr_q        <= '0;
                flush_all_q  <= flush_all;
                flush_asid_q <= flush_asid;
            end else if (state_q == FLUSH_SWEEP) begin
                ptr_q <= ptr_q + IDX_W'(1);
            end
        end
    end

    assign flush_busy  = (state_q == FLUSH_SWEEP);
    assign flush_done  = (state_q == FLUSH_DONE);
    assign flush_state = state_q;

    // ---------------- Random / Wired ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            random_q <= LAST;
            wired_q  <= '0;
        end else if (wired_write) begin
            wired_q  <= wired_value;
            random_q <= LAST;
        end else if (random_q <= wired_q) begin
            random_q <= LAST;
        end else begin
            random_q <= random_q - IDX_W'(1);
        end
    end

    assign random_index = random_q;

    // ---------------- entry storage ----------------
    assign wr_idx = write_random ? random_q : write_index;

    // Write is applied after the sweep clear so a same-cycle write to the visited entry wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TLB_NUM; i++) entries[i] <= '0;
            entry_valid <= '0;
        end else begin
            if (sweep_clear) entry_valid[ptr_q] <= 1'b0;
            if (write_enabled) begin
                entries[wr_idx]     <= write_data;
                entry_valid[wr_idx] <= 1'b1;
            end
        end
    end

    assign read_data        = entries[read_index];
    assign read_entry_valid = entry_valid[read_index];

    // ---------------- search ports ----------------
    logic [TLB_NUM-1:0] match     [SEARCH_PORTS];
    logic [SEARCH_PORTS-1:0] enc_found, enc_multi;
    logic [IDX_W-1:0]   enc_index [SEARCH_PORTS];
    search_result_t     res_d     [SEARCH_PORTS];

    always_comb begin
        for (int p = 0; p < SEARCH_PORTS; p++) begin
            for (int i = 0; i < TLB_NUM; i++) begin
                match[p][i] = entry_valid[i]
                            & (entries[i].vpn2 == search_request[p].vpn2)
                            & (entries[i].is_global | (entries[i].asid == search_request[p].asid));
            end
        end
    end

    for (genvar p = 0; p < SEARCH_PORTS; p++) begin : g_enc
        tlb_match_encoder #(.N(TLB_NUM), .IDX_W(IDX_W)) u_enc (
            .match     (match[p]),
            .found     (enc_found[p]),
            .index     (enc_index[p]),
            .multi_hit (enc_multi[p])
        );
    end

    always_comb begin
        for (int p = 0; p < SEARCH_PORTS; p++) begin
            res_d[p] = '0;
            if (enc_found[p]) begin
                res_d[p].found = 1'b1;
                res_d[p].index = IDX_MAX_W'(enc_index[p]);
                res_d[p].page  = search_request[p].is_odd_page ? entries[enc_index[p]].page1
                                                               : entries[enc_index[p]].page0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_valid  <= '0;
            search_result <= '0;
            multi_hit     <= '0;
        end else begin
            result_valid <= search_valid;
            for (int p = 0; p < SEARCH_PORTS; p++) begin
                if (search_valid[p]) begin
                    search_result[p] <= res_d[p];
                    multi_hit[p]     <= enc_multi[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_multiport.sv
// Self-checking bench for tlb_multiport: directed scenarios then randomized traffic,
// compared every cycle against a behavioural model of the TLB.
module tb_tlb_multiport;
    import tlb_params::*;

    localparam int N  = 16;
    localparam int P  = 2;
    localparam int IW = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [P-1:0]            search_valid;
    search_request_t [P-1:0] search_request;
    logic [P-1:0]            result_valid;
    search_result_t [P-1:0]  search_result;
    logic [P-1:0]            multi_hit;
    logic                    write_enabled, write_random, wired_write;
    logic [IW-1:0]           write_index, wired_value, random_index, read_index;
    tlb_request_t            write_data, read_data;
    logic                    read_entry_valid;
    logic                    flush_request, flush_all, flush_busy, flush_done;
    logic [7:0]              flush_asid;
    flush_state_t            flush_state;

    tlb_multiport #(.TLB_NUM(N), .SEARCH_PORTS(P)) dut (
        .clock(clock), .reset_n(reset_n),
        .search_valid(search_valid), .search_request(search_request),
        .result_valid(result_valid), .search_result(search_result), .multi_hit(multi_hit),
        .write_enabled(write_enabled), .write_random(write_random),
        .write_index(write_index), .write_data(write_data),
        .wired_write(wired_write), .wired_value(wired_value), .random_index(random_index),
        .read_index(read_index), .read_data(read_data), .read_entry_valid(read_entry_valid),
        .flush_request(flush_request), .flush_all(flush_all), .flush_asid(flush_asid),
        .flush_busy(flush_busy), .flush_done(flush_done), .flush_state(flush_state)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model
    tlb_request_t   m_entry [N];
    logic [N-1:0]   m_valid;
    int             m_k;       // cycles since last Random reload (1 = just reloaded)
    int             m_wired;
    int             m_age;     // 0 idle, else edges since flush request accepted
    logic           m_fall;
    logic [7:0]     m_fasid;
    search_result_t m_res [P];
    logic [P-1:0]   m_mh, m_rv;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_random();
        if (m_wired >= N - 1) return N - 1;
        return (N - 1) - ((m_k - 1) % (N - m_wired));
    endfunction

    function automatic void model_search(input search_request_t r, output search_result_t res,
                                         output logic mh);
        int hits = 0;
        res = '0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_entry[i].vpn2 == r.vpn2 &&
                (m_entry[i].is_global || m_entry[i].asid == r.asid)) begin
                if (hits == 0) begin
                    res.found = 1'b1;
                    res.index = IDX_MAX_W'(i);
                    res.page  = r.is_odd_page ? m_entry[i].page1 : m_entry[i].page0;
                end
                hits++;
            end
        end
        mh = (hits > 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_entry[i] = '0;
        m_valid = '0;
        m_k = 1; m_wired = 0; m_age = 0; m_fall = 1'b0; m_fasid = '0;
        for (int p = 0; p < P; p++) m_res[p] = '0;
        m_mh = '0; m_rv = '0;
    endtask

    task automatic compare_all();
        for (int p = 0; p < P; p++) begin
            check("result_valid", result_valid[p], m_rv[p]);
            check("search_result", search_result[p], m_res[p]);
            check("multi_hit", multi_hit[p], m_mh[p]);
        end
        check("random_index", random_index, model_random());
        check("flush_busy", flush_busy, (m_age >= 1 && m_age <= N));
        check("flush_done", flush_done, (m_age == N + 1));
        check("read_data", read_data, m_entry[read_index]);
        check("read_entry_valid", read_entry_valid, m_valid[read_index]);
    endtask

    // One clock: update the model from the inputs seen at this edge, then compare.
    task automatic step();
        int cur, widx, v;
        search_result_t r;
        logic mh;
        for (int p = 0; p < P; p++) begin
            if (search_valid[p]) begin
                model_search(search_request[p], r, mh);
                m_res[p] = r;
                m_mh[p]  = mh;
            end
        end
        m_rv = search_valid;
        cur = model_random();
        if (m_age >= 1 && m_age <= N) begin
            v = m_age - 1;
            if (m_fall || (!m_entry[v].is_global && m_entry[v].asid == m_fasid)) m_valid[v] = 1'b0;
        end
        if (write_enabled) begin
            widx = write_random ? cur : int'(write_index);
            m_entry[widx] = write_data;
            m_valid[widx] = 1'b1;
        end
        if (m_age == 0) begin
            if (flush_request) begin
                m_age = 1; m_fall = flush_all; m_fasid = flush_asid;
            end
        end else if (m_age == N + 1) m_age = 0;
        else m_age++;
        if (wired_write) begin
            m_wired = int'(wired_value);
            m_k = 1;
        end else m_k++;
        @(posedge clock); #1;
        write_enabled = 1'b0; wired_write = 1'b0; flush_request = 1'b0; search_valid = '0;
        compare_all();
    endtask

    task automatic write_req(input int idx, input logic [18:0] vpn2, input logic [7:0] asid,
                             input logic g, input logic [19:0] pfn1);
        write_enabled = 1'b1;
        write_random  = 1'b0;
        write_index   = IW'(idx);
        write_data = '0;
        write_data.vpn2 = vpn2;
        write_data.asid = asid;
        write_data.is_global = g;
        write_data.page1 = '{pfn: pfn1, c: 3'd3, d: 1'b1, v: 1'b1};
        write_data.page0 = '{pfn: pfn1 ^ 20'hFFFFF, c: 3'd2, d: 1'b0, v: 1'b1};
    endtask

    task automatic check_reset_outputs();
        for (int p = 0; p < P; p++) begin
            check("rst_result_valid", result_valid[p], 1'b0);
            check("rst_search_result", search_result[p], '0);
            check("rst_multi_hit", multi_hit[p], 1'b0);
        end
        check("rst_random", random_index, 4'd15);
        check("rst_flush_busy", flush_busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_flush_state", flush_state, FLUSH_IDLE);
        for (int i = 0; i < N; i++) begin
            read_index = IW'(i);
            #0.1;
            check("rst_entry_valid", read_entry_valid, 1'b0);
            check("rst_read_data", read_data, '0);
        end
        read_index = '0;
    endtask

    initial begin
        int busy_cnt, done_cnt;
        search_valid = '0; search_request = '0;
        write_enabled = 1'b0; write_random = 1'b0; write_index = '0; write_data = '0;
        wired_write = 1'b0; wired_value = '0; read_index = '0;
        flush_request = 1'b0; flush_all = 1'b0; flush_asid = '0;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;

        // Lookup on an empty TLB misses
        search_valid[0] = 1'b1;
        search_request[0] = '0;
        step();
        check("empty_found", search_result[0].found, 1'b0);

        // Indexed write then odd-page lookup; wrong ASID misses
        write_req(3, 19'h12345, 8'h07, 1'b0, 20'hABCDE);
        step();
        search_valid = 2'b11;
        search_request[0] = '{vpn2: 19'h12345, is_odd_page: 1'b1, asid: 8'h07};
        search_request[1] = '{vpn2: 19'h12345, is_odd_page: 1'b1, asid: 8'h08};
        step();
        check("hit_found", search_result[0].found, 1'b1);
        check("hit_index", search_result[0].index, 6'd3);
        check("hit_pfn", search_result[0].page.pfn, 20'hABCDE);
        check("asid_miss", search_result[1].found, 1'b0);

        // Two global entries with the same vpn2: lowest index wins, multi-hit flagged
        write_req(2, 19'h00777, 8'h11, 1'b1, 20'h11111);
        step();
        write_req(9, 19'h00777, 8'h22, 1'b1, 20'h99999);
        step();
        search_valid = 2'b01;
        search_request[0] = '{vpn2: 19'h00777, is_odd_page: 1'b0, asid: 8'h33};
        step();
        check("multi_found", search_result[0].found, 1'b1);
        check("multi_index", search_result[0].index, 6'd2);
        check("multi_flag", multi_hit[0], 1'b1);

        // Wired = 4: Random reloads to 15 and counts down; TLBWR lands at 7
        wired_write = 1'b1; wired_value = 4'd4;
        step();
        check("wired_reload", random_index, 4'd15);
        repeat (8) step();
        check("random_at_7", random_index, 4'd7);
        write_req(0, 19'h0ABCD, 8'h05, 1'b0, 20'h77777);
        write_random = 1'b1;
        step();
        write_random = 1'b0;
        read_index = 4'd7;
        #1;
        check("twr_valid", read_entry_valid, 1'b1);
        check("twr_vpn2", read_data.vpn2, 19'h0ABCD);
        repeat (14) step();

        // ASID-selective flush
        write_req(1, 19'h00100, 8'h05, 1'b0, 20'h00001);
        step();
        write_req(2, 19'h00101, 8'h05, 1'b1, 20'h00002);
        step();
        write_req(3, 19'h00102, 8'h06, 1'b0, 20'h00003);
        step();
        flush_request = 1'b1; flush_all = 1'b0; flush_asid = 8'h05;
        step();
        busy_cnt = flush_busy ? 1 : 0;
        done_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (flush_busy) busy_cnt++;
            if (flush_done) done_cnt++;
        end
        check("flush_busy_cycles", busy_cnt, 16);
        check("flush_done_pulses", done_cnt, 1);
        read_index = 4'd1; #1; check("flush_e1", read_entry_valid, 1'b0);
        read_index = 4'd2; #1; check("flush_e2_global", read_entry_valid, 1'b1);
        read_index = 4'd3; #1; check("flush_e3_other", read_entry_valid, 1'b1);

        // flush_all with a write to entry 5 in the cycle the sweep visits it
        flush_request = 1'b1; flush_all = 1'b1;
        step();
        repeat (5) step();
        write_req(5, 19'h00555, 8'h01, 1'b0, 20'h55555);
        step();
        repeat (12) step();
        read_index = 4'd5; #1; check("sweep_write_wins", read_entry_valid, 1'b1);
        read_index = 4'd3; #1; check("flush_all_e3", read_entry_valid, 1'b0);

        // Reset in the middle of a sweep
        search_valid = 2'b01;
        search_request[0] = '{vpn2: 19'h00555, is_odd_page: 1'b1, asid: 8'h01};
        step();
        flush_request = 1'b1; flush_all = 1'b1;
        step();
        repeat (5) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            search_valid = P'($urandom_range(0, 3));
            for (int p = 0; p < P; p++)
                search_request[p] = '{vpn2: 19'($urandom_range(0, 3)),
                                      is_odd_page: 1'($urandom_range(0, 1)),
                                      asid: 8'($urandom_range(0, 3))};
            if ($urandom_range(0, 2) == 0) begin
                write_enabled = 1'b1;
                write_random  = 1'($urandom_range(0, 1));
                write_index   = IW'($urandom_range(0, N - 1));
                write_data.vpn2 = 19'($urandom_range(0, 3));
                write_data.asid = 8'($urandom_range(0, 3));
                write_data.is_global = ($urandom_range(0, 3) == 0);
                write_data.page0 = 25'($urandom);
                write_data.page1 = 25'($urandom);
            end
            if ($urandom_range(0, 40) == 0) begin
                wired_write = 1'b1;
                wired_value = IW'($urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 30) == 0) begin
                flush_request = 1'b1;
                flush_all  = 1'($urandom_range(0, 1));
                flush_asid = 8'($urandom_range(0, 3));
            end
            read_index = IW'($urandom_range(0, N - 1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
